// File: rtl/div_restoring_32_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_restoring_32_if
//  Description : Request/result bundle for the 32-bit restoring divider.
//                The master side (operand registers / control) raises start
//                with Ra/Rb. The slave side (the divider) returns the
//                quotient, the remainder and the busy/done/div_by_zero status.
//  Signals     : start        - request a division (sampled only when idle)
//                Ra, Rb       - dividend, divisor
//                quotient     - result destined for Zlow
//                remainder    - result destined for Zhigh
//                busy         - division in progress
//                done         - one-cycle pulse, results valid
//                div_by_zero  - divisor was zero (valid with done)
//  Revision    : 1.0 - initial release
// ============================================================================
interface div_restoring_32_if;
    logic        start;
    logic [31:0] Ra;
    logic [31:0] Rb;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    modport master (
        output start,
        output Ra,
        output Rb,
        input  quotient,
        input  remainder,
        input  busy,
        input  done,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  Ra,
        input  Rb,
        output quotient,
        output remainder,
        output busy,
        output done,
        output div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/div_restoring_32.sv
`default_nettype none
// ============================================================================
//  Module      : div_restoring_32
//  Description : Sequential 32-bit restoring divider for the ALU DIV op.
//                One trial subtraction per cycle on a 33-bit partial
//                remainder. The latency is fixed: accept edge E0, 32
//                iterations (E1..E32), a fix-up stage (E33) and a done stage
//                (E34). done is high in the cycle after E34. A zero divisor
//                skips straight to the done stage, so done follows E1.
//  Config      : SIGNED_DIV_EN - when defined, two's-complement signed
//                division (truncating quotient, remainder carries the
//                dividend sign). When undefined, unsigned division.
//  Ports       : clk  - system clock, rising edge
//                clr  - asynchronous active-high reset
//                bus  - div_restoring_32_if.slave (start, Ra, Rb in;
//                       quotient, remainder, busy, done, div_by_zero out)
//  Revision    : 1.0 - initial release
// ============================================================================
module div_restoring_32 (
    input  wire logic               clk,
    input  wire logic               clr,
    div_restoring_32_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [32:0] part_rem;      // partial remainder P
    logic [31:0] quo;           // shifting quotient Q (dividend at start)
    logic [31:0] divisor;
    logic [5:0]  count;
    logic        zero_div;      // captured divisor was zero

    logic [31:0] quotient_reg;
    logic [31:0] remainder_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        dbz_reg;

`ifdef SIGNED_DIV_EN
    logic        sign_q;        // quotient must be negated
    logic        sign_r;        // remainder must be negated (dividend sign)
`endif

    // ------------------------------------------------------------------
    // Operand conditioning
    // ------------------------------------------------------------------
    logic [31:0] a_mag;
    logic [31:0] b_mag;

`ifdef SIGNED_DIV_EN
    // The magnitude of 32'h80000000 is 2^31, which still fits as unsigned.
    assign a_mag = bus.Ra[31] ? (~bus.Ra + 32'd1) : bus.Ra;
    assign b_mag = bus.Rb[31] ? (~bus.Rb + 32'd1) : bus.Rb;
`else
    assign a_mag = bus.Ra;
    assign b_mag = bus.Rb;
`endif

    // A start that lands in the done cycle is refused. The FSM is already
    // back in IDLE at that point, so the done flag gates acceptance.
    logic accept;
    assign accept = (state == IDLE) && bus.start && !done_reg;

    // ------------------------------------------------------------------
    // One restoring step
    // ------------------------------------------------------------------
    // {P,Q} shifted left by one. The trial difference is kept one bit
    // wider than P so that its top bit is a true sign even when the
    // shifted value exceeds 2^32.
    logic [33:0] shifted;
    logic [33:0] trial;
    logic        trial_neg;

    assign shifted   = {part_rem, quo[31]};
    assign trial     = shifted - {2'b00, divisor};
    assign trial_neg = trial[33];

    // ------------------------------------------------------------------
    // Fix-up values
    // ------------------------------------------------------------------
    logic [31:0] fix_quotient;
    logic [31:0] fix_remainder;
    logic [31:0] zero_remainder;

`ifdef SIGNED_DIV_EN
    assign fix_quotient   = sign_q ? (~quo + 32'd1) : quo;
    assign fix_remainder  = sign_r ? (~part_rem[31:0] + 32'd1) : part_rem[31:0];
    // quo still holds |Ra| on the zero-divisor path; restoring the sign
    // reproduces Ra exactly.
    assign zero_remainder = sign_r ? (~quo + 32'd1) : quo;
`else
    assign fix_quotient   = quo;
    assign fix_remainder  = part_rem[31:0];
    assign zero_remainder = quo;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (bus.Rb == 32'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (count == 6'd31) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            part_rem      <= '0;
            quo           <= '0;
            divisor       <= '0;
            count         <= '0;
            zero_div      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            dbz_reg       <= 1'b0;
`ifdef SIGNED_DIV_EN
            sign_q        <= 1'b0;
            sign_r        <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        busy_reg <= 1'b1;
                        dbz_reg  <= 1'b0;
                        divisor  <= b_mag;
                        quo      <= a_mag;
                        part_rem <= '0;
                        count    <= '0;
                        zero_div <= (bus.Rb == 32'd0);
`ifdef SIGNED_DIV_EN
                        sign_q   <= bus.Ra[31] ^ bus.Rb[31];
                        sign_r   <= bus.Ra[31];
`endif
                    end
                end
                RUN: begin
                    part_rem <= trial_neg ? shifted[32:0] : trial[32:0];
                    quo      <= {quo[30:0], ~trial_neg};
                    count    <= count + 6'd1;
                end
                FIX: begin
                    quotient_reg  <= fix_quotient;
                    remainder_reg <= fix_remainder;
                end
                DONE: begin
                    done_reg <= 1'b1;
                    busy_reg <= 1'b0;
                    if (zero_div) begin
                        quotient_reg  <= 32'hFFFF_FFFF;
                        remainder_reg <= zero_remainder;
                        dbz_reg       <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.div_by_zero = dbz_reg;

endmodule
`default_nettype wire
